// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access-size encodings,
// FSM state enum and the alignment helpers used at request capture.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsuSize_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_RESP
  } lsuState_t;

  // Reserved size behaves exactly like a word access.
  function automatic logic isWordSize(lsuSize_t size);
    return (size == SZ_WORD) || (size == SZ_RSVD);
  endfunction

  // Offset bits that the access size cannot use are forced to alignment.
  function automatic logic [1:0] alignOffset(lsuSize_t size, logic [1:0] offset);
    case (size)
      SZ_BYTE: return offset;
      SZ_HALF: return {offset[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic isMisaligned(lsuSize_t size, logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      default: return offset != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake between the execute stage (master) and the
// load/store unit (slave).
interface load_store_unit_if #(
  parameter int ADDR_W = 9
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: extracts and extends load data from a
// memory word, and merges sub-word store data into a memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  lsuSize_t    size,
  input  logic [1:0]  offset,
  input  logic        isUnsigned,
  input  logic [31:0] memWord,
  input  logic [31:0] storeData,
  output logic [31:0] loadData,
  output logic [31:0] mergedWord
);

  logic [7:0]  laneByte;
  logic [15:0] laneHalf;

  // Select the addressed lane for loads and overwrite it for stores.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (that would infer a latch).
    laneByte   = memWord[{offset, 3'b000} +: 8];
    laneHalf   = offset[1] ? memWord[31:16] : memWord[15:0];
    loadData   = memWord;
    mergedWord = storeData;
    case (size)
      SZ_BYTE: begin
        loadData   = isUnsigned ? {24'h0, laneByte} : {{24{laneByte[7]}}, laneByte};
        mergedWord = memWord;
        mergedWord[{offset, 3'b000} +: 8] = storeData[7:0];
      end
      SZ_HALF: begin
        loadData   = isUnsigned ? {16'h0, laneHalf} : {{16{laneHalf[15]}}, laneHalf};
        mergedWord = offset[1] ? {storeData[15:0], memWord[15:0]}
                               : {memWord[31:16], storeData[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts byte-addressed requests and drives the word-only
// data_memory port, doing read-modify-write for sub-word stores.
// Optional build macro LSU_ALIGN_CHECK_EN: when defined, misaligned requests
// complete immediately with resp_err=1 instead of being forced to alignment.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              reset_n,
  load_store_unit_if.slave  lsu,
  output logic [ADDR_W-3:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

`ifdef LSU_ALIGN_CHECK_EN
  localparam bit alignCheckEn = 1'b1;
`else
  localparam bit alignCheckEn = 1'b0;
`endif

  lsuState_t   state;
  lsuSize_t    capSize;
  logic [1:0]  capOffset;
  logic        capWrite;
  logic        capUnsigned;
  logic [31:0] capWdata;
  lsuSize_t    reqSize;
  logic [31:0] loadData;
  logic [31:0] mergedWord;

  assign reqSize = lsuSize_t'(lsu.req_size);

  lsu_lane_align u_laneAlign (
    .size      (capSize),
    .offset    (capOffset),
    .isUnsigned(capUnsigned),
    .memWord   (mem_rdata),
    .storeData (capWdata),
    .loadData  (loadData),
    .mergedWord(mergedWord)
  );

  // Request FSM with all outputs registered; reset abandons any transaction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      lsu.req_ready  <= 1'b1;
      lsu.resp_valid <= 1'b0;
      lsu.resp_rdata <= '0;
      lsu.resp_err   <= 1'b0;
      mem_address    <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_wdata      <= '0;
      capSize        <= SZ_BYTE;
      capOffset      <= '0;
      capWrite       <= 1'b0;
      capUnsigned    <= 1'b0;
      capWdata       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      case (state)
        ST_IDLE: begin
          if (lsu.req_valid) begin
            lsu.req_ready <= 1'b0;
            capSize       <= reqSize;
            capOffset     <= alignOffset(reqSize, lsu.req_addr[1:0]);
            capWrite      <= lsu.req_write;
            capUnsigned   <= lsu.req_unsigned;
            capWdata      <= lsu.req_wdata;
            mem_address   <= lsu.req_addr[ADDR_W-1:2];
            if (alignCheckEn && isMisaligned(reqSize, lsu.req_addr[1:0])) begin
              state          <= ST_RESP;
              lsu.resp_valid <= 1'b1;
              lsu.resp_err   <= 1'b1;
              lsu.resp_rdata <= '0;
            end else if (lsu.req_write && isWordSize(reqSize)) begin
              state     <= ST_WRITE;
              mem_write <= 1'b1;
              mem_wdata <= lsu.req_wdata;
            end else begin
              state    <= ST_READ;
              mem_read <= 1'b1;
            end
          end
        end
        ST_READ: begin
          mem_read <= 1'b0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (capWrite) begin
            state     <= ST_WRITE;
            mem_write <= 1'b1;
            mem_wdata <= mergedWord;
          end else begin
            state          <= ST_RESP;
            lsu.resp_valid <= 1'b1;
            lsu.resp_rdata <= loadData;
            lsu.resp_err   <= 1'b0;
          end
        end
        ST_WRITE: begin
          mem_write      <= 1'b0;
          mem_wdata      <= '0;
          state          <= ST_RESP;
          lsu.resp_valid <= 1'b1;
          lsu.resp_rdata <= '0;
          lsu.resp_err   <= 1'b0;
        end
        ST_RESP: begin
          lsu.resp_valid <= 1'b0;
          lsu.resp_rdata <= '0;
          lsu.resp_err   <= 1'b0;
          lsu.req_ready  <= 1'b1;
          state          <= ST_IDLE;
        end
        default: begin
          state         <= ST_IDLE;
          lsu.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the execute stage and `data_memory`. It accepts byte-addressed load and store requests over a valid/ready handshake and drives `data_memory`'s word-only port. Sub-word stores are done as read-modify-write. Load data comes back byte- or halfword-extracted and sign- or zero-extended. Single clock domain; one request in flight at a time.

## Interface
- `ADDR_W`, default 9: byte-address width. The word index is `ADDR_W-2` bits, matching the 7-bit `data_memory` address.
- `clock` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `req_valid` in 1: request present; must be held stable until accepted.
- `req_ready` out 1: block can accept; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in `ADDR_W`: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse; no back-pressure.
- `resp_rdata` out 32: load result; 0 for stores.
- `resp_err` out 1: misaligned access; qualified by `resp_valid`.
- `mem_address` out `ADDR_W-2`: word index, `req_addr[ADDR_W-1:2]`.
- `mem_read` out 1: to `MemRead`.
- `mem_write` out 1: to `MemWrite`.
- `mem_wdata` out 32: to `WriteData`.
- `mem_rdata` in 32: from `ReadData`; valid the cycle after `mem_read` is high.

## Operation
- **Request capture:** accept when `req_valid && req_ready`. Address, size, write, unsigned and wdata are registered at that edge.
- **Byte lanes:** little-endian. Byte lane = `addr[1:0]`; half lane = `addr[1]` (bits 15:0 or 31:16).
- **FSM states:** IDLE, READ, WAIT, WRITE, RESP.
- **FSM transitions:**
  - IDLE → READ: any load, or a sub-word store.
  - IDLE → WRITE: word store.
  - IDLE → RESP: misaligned request (with check enabled).
  - READ → WAIT.
  - WAIT → RESP for a load; WAIT → WRITE for a store.
  - WRITE → RESP.
  - RESP → IDLE.
- **READ:** `mem_read`=1 for exactly one cycle.
- **WAIT:** `mem_rdata` is registered at the edge ending WAIT.
  - Load: extract the addressed lane, then extend to 32 bits.
  - Sub-word store: merge `req_wdata[7:0]` or `[15:0]` into the addressed lane; other lanes are preserved.
- **WRITE:** `mem_write`=1 for exactly one cycle; `mem_wdata` is the merged word, or `req_wdata` for word stores.
- **RESP:** `resp_valid`=1 for one cycle; `resp_rdata` and `resp_err` are held stable during it.
- **Idle outputs:** `mem_read`, `mem_write` and `mem_wdata` are 0 outside their states. `mem_address` holds the captured index from accept until IDLE.

## Timing
- **Reset values:** state IDLE, `req_ready`=1, all other outputs 0.
- **Latency, accept edge to `resp_valid` high:**
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
  - misaligned (check enabled): 1 cycle
- **Throughput:** the next request is accepted at the earliest on the cycle after RESP.
- **Requests while busy:** `req_valid` outside IDLE is ignored; the requester holds its request.
- **Reset mid-operation:** `mem_read` and `mem_write` drop asynchronously and the transaction is abandoned. A `data_memory` write that has not reached its clock edge is not performed. No `resp_valid` is issued.
- **Address decode:** the top word index wraps naturally; no range checking is done.

## Configuration
- **`LSU_ALIGN_CHECK_EN` defined:**
  - Misaligned requests are halfs with `addr[0]`=1, and words or reserved sizes with `addr[1:0]`≠0.
  - They produce no memory access and complete with `resp_err`=1 and `resp_rdata`=0.
- **`LSU_ALIGN_CHECK_EN` undefined:**
  - The low offset bits are forced to alignment (half: `addr[0]` ignored; word: `addr[1:0]` ignored).
  - `resp_err` is tied to 0.

## Structure
- **Package `lsu_pkg`:** size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`) and the FSM state enum.
- **Sub-module `lsu_lane_align`:** combinational. Load extract/extend and store merge, driven by size, offset, unsigned flag, memory word and store data. The FSM and handshake stay in `load_store_unit`.

## Test plan
- **Word store/load:** word store `0xDEADBEEF` to addr `0x04` → `mem_write` pulse at index 1, `resp_valid` 2 cycles after accept. Then a word load from `0x04` → `resp_rdata`=`0xDEADBEEF` 3 cycles after accept.
- **Byte store (RMW):** byte store `0xAA` to addr `0x06` over word `0x11223344` → READ, WAIT, WRITE with `mem_wdata`=`0x11AA3344`; `resp_valid` 4 cycles after accept.
- **Signed/unsigned loads:** with word `0x80F0` at index 0:
  - signed half load at `0x00` → `0xFFFF80F0`
  - unsigned → `0x000080F0`
  - signed byte at `0x01` → `0xFFFFFF80`
- **Misaligned load:** word load at `0x03`.
  - With `LSU_ALIGN_CHECK_EN`: `resp_err`=1, `resp_rdata`=0, no `mem_read`.
  - Without it: reads index 0, `resp_err`=0.
- **Handshake:** hold `req_valid` high during a busy load → second request accepted only the cycle after RESP; exactly two responses.
- **Reset mid-operation:** assert `reset_n`=0 during WAIT of a byte store → `mem_write` never pulses, memory unchanged, `req_ready`=1 after release.
